// File: rtl/secuenciador_contador.sv
// rtl/secuenciador_contador.sv - command sequencer driving a 4-bit mode-controlled counter
module secuenciador_contador #(
   parameter int NW = 5
) (
   input  logic          CLK,
   input  logic          RESET_L,
   input  logic          CMD_VALID,
   output logic          CMD_READY,
   input  logic [1:0]    CMD_MODO,
   input  logic [3:0]    CMD_D,
   input  logic [NW-1:0] CMD_N,
   input  logic          ABORT,
   output logic          ENB,
   output logic [1:0]    MODO,
   output logic [3:0]    D,
   input  logic [3:0]    Q,
   input  logic          RCO,
   output logic          DONE,
   output logic [3:0]    Q_FINAL,
   output logic [3:0]    WRAPS
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DRAIN} state_t;

   localparam logic [NW-1:0] ONE = NW'(1);

   state_t        state;
   logic [1:0]    lat_modo;
   logic [3:0]    lat_d;
   logic [NW-1:0] lat_n;
   logic [NW-1:0] rem;

   // Ready depends on state alone so the control side never sees a path through CMD_*
   assign CMD_READY = (state == S_IDLE);

   // Sequencer FSM; counter controls are registered as the values for the state being entered
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state    <= S_IDLE;
         lat_modo <= 2'b00;
         lat_d    <= 4'd0;
         lat_n    <= '0;
         rem      <= '0;
         ENB      <= 1'b0;
         MODO     <= 2'b00;
         D        <= 4'd0;
         DONE     <= 1'b0;
         Q_FINAL  <= 4'd0;
         WRAPS    <= 4'd0;
      end else begin
         DONE <= 1'b0;
         // Wrap pulses are observed while counting and during the drain cycle, since the
         // counter may flag the last step's wrap one cycle late
         if ((state == S_COUNT || state == S_DRAIN) && RCO && WRAPS != 4'hf)
            WRAPS <= WRAPS + 4'd1;
         case (state)
            S_IDLE: begin
               if (CMD_VALID) begin
                  lat_modo <= CMD_MODO;
                  lat_d    <= CMD_D;
                  lat_n    <= CMD_N;
                  WRAPS    <= 4'd0;
                  state    <= S_LOAD;
                  ENB      <= 1'b1;
                  MODO     <= 2'b11;
                  D        <= CMD_D;
               end
            end
            S_LOAD: begin
               if (lat_modo == 2'b11 || lat_n == '0 || ABORT) begin
                  state <= S_DRAIN;
                  ENB   <= 1'b0;
                  MODO  <= 2'b00;
                  D     <= 4'd0;
               end else begin
                  state <= S_COUNT;
                  rem   <= lat_n;
                  ENB   <= 1'b1;
                  MODO  <= lat_modo;
                  D     <= 4'd0;
               end
            end
            S_COUNT: begin
               rem <= rem - ONE;
               // The counter takes this edge's step regardless; we only stop afterwards
               if (rem == ONE || ABORT) begin
                  state <= S_DRAIN;
                  ENB   <= 1'b0;
                  MODO  <= 2'b00;
                  D     <= 4'd0;
               end
            end
            S_DRAIN: begin
               Q_FINAL <= Q;
               DONE    <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               ENB   <= 1'b0;
               MODO  <= 2'b00;
               D     <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_contador.sv
// tb/tb_secuenciador_contador.sv - randomized scoreboard bench for secuenciador_contador
module tb_secuenciador_contador;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_modo = 2'b00;
   logic [3:0] cmd_d = 4'd0;
   logic [4:0] cmd_n = 5'd0;
   logic       abort = 1'b0;
   logic       enb;
   logic [1:0] modo;
   logic [3:0] d;
   logic [3:0] q = 4'd0;
   logic       rco = 1'b0;
   logic       done;
   logic [3:0] q_final;
   logic [3:0] wraps;

   typedef struct {
      int q;
      int w;
      int dc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   prev_load = 1'b0;

   secuenciador_contador #(.NW(5)) dut (
      .CLK(clk), .RESET_L(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_MODO(cmd_modo), .CMD_D(cmd_d), .CMD_N(cmd_n), .ABORT(abort),
      .ENB(enb), .MODO(modo), .D(d), .Q(q), .RCO(rco),
      .DONE(done), .Q_FINAL(q_final), .WRAPS(wraps)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter under control: RCO pulses for one cycle after a step that wrapped
   always @(posedge clk) begin
      if (enb) begin
         case (modo)
            2'b00: begin rco <= (q == 4'd15); q <= q + 4'd1; end
            2'b01: begin rco <= (q == 4'd0);  q <= q - 4'd1; end
            2'b10: begin rco <= (q < 4'd3);   q <= q - 4'd3; end
            default: begin rco <= 1'b0;       q <= d;        end
         endcase
      end else begin
         rco <= 1'b0;
      end
   end

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Reference: walk the requested steps arithmetically, counting range escapes as wraps
   function automatic void model(input int mode, input int dv, input int n, input int ab,
                                 output int qf, output int wr, output int st);
      int delta;
      int nq;
      qf = dv;
      wr = 0;
      st = 0;
      if (mode != 3 && n > 0) begin
         st = (ab > 0 && ab < n) ? ab : n;
         delta = (mode == 0) ? 1 : (mode == 1) ? -1 : -3;
         for (int i = 0; i < st; i++) begin
            nq = qf + delta;
            if (nq < 0 || nq > 15) wr++;
            qf = (nq + 16) % 16;
         end
      end
      if (wr > 15) wr = 15;
   endfunction

   task automatic send(input int mode, input int dv, input int n, input int ab,
                       input bit hold, input bit in_done);
      int   qf, wr, st, t;
      exp_t e;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_modo  = mode[1:0];
      cmd_d     = dv[3:0];
      cmd_n     = n[4:0];
      t = 0;
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
      end else begin
         if (in_done) chk("accept_in_done", done, 1);
         model(mode, dv, n, ab, qf, wr, st);
         e.q  = qf;
         e.w  = wr;
         e.dc = cyc + 1 + st + 2;
         sb.push_back(e);
         @(negedge clk);
         if (!hold) cmd_valid = 1'b0;
         if (ab > 0 && mode != 3 && n > 0) begin
            repeat (ab) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
         end
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: pop the oldest expectation whenever DONE is presented
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_load = 1'b0;
      end else begin
         if (prev_load) chk("load_one_cycle", int'(enb && modo == 2'b11), 0);
         prev_load = enb && (modo == 2'b11);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("q_final", q_final, e.q);
               chk("wraps", wraps, e.w);
               chk("done_cycle", cyc, e.dc);
            end
         end
      end
   end

   initial begin
      int seq[5];
      int mode, dv, n, ab;
      seq = '{13, 10, 7, 4, 1};

      repeat (3) @(negedge clk);
      chk("rst_enb", enb, 0);
      chk("rst_modo", modo, 0);
      chk("rst_d", d, 0);
      chk("rst_done", done, 0);
      chk("rst_q_final", q_final, 0);
      chk("rst_wraps", wraps, 0);
      chk("rst_ready", cmd_ready, 1);
      rst_n = 1'b1;

      send(0, 0, 16, 0, 0, 0);
      wait_idle();

      send(2, 0, 5, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("down3_q", q, seq[i]);
      end
      wait_idle();

      send(3, 9, 7, 0, 0, 0);
      chk("loadonly_modo", modo, 3);
      chk("loadonly_enb", enb, 1);
      @(negedge clk);
      chk("loadonly_enb_off", enb, 0);
      wait_idle();

      send(1, 8, 10, 3, 0, 0);
      wait_idle();

      send(0, 7, 0, 0, 0, 0);
      wait_idle();

      send(2, 0, 5, 0, 1, 0);
      send(0, 3, 4, 0, 0, 1);
      wait_idle();

      send(0, 0, 20, 0, 0, 0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("midrst_enb", enb, 0);
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_done", done, 0);
      chk("midrst_wraps", wraps, 0);
      rst_n = 1'b1;
      send(3, 5, 0, 0, 0, 0);
      wait_idle();

      repeat (30) begin
         mode = int'($urandom_range(3, 0));
         dv   = int'($urandom_range(15, 0));
         n    = int'($urandom_range(31, 0));
         ab   = 0;
         if (n > 0 && $urandom_range(2, 0) == 0) ab = int'($urandom_range(n, 1));
         send(mode, dv, n, ab, 0, 0);
         wait_idle();
         repeat ($urandom_range(3, 0)) begin
            abort = 1'($urandom_range(1, 0));
            @(negedge clk);
         end
         abort = 1'b0;
      end

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/secuenciador_contador.md
# secuenciador_contador

Command-driven sequencer for the 4-bit mode-controlled counter register. It takes one command at a time over a valid/ready handshake. For each command it drives the counter's `ENB`/`MODO`/`D` inputs through a fixed sequence: parallel load, then N counting steps in the requested mode, then stop. It reports the final `Q` and the number of wrap-arounds (`RCO` pulses) seen. It sits between the control logic and the counter, and is the only agent that drives the counter's inputs.

## Interface
Parameters:
- `NW`, 5: width of the step-count field; up to 2^NW-1 steps.

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RESET_L`  in  1  asynchronous reset, active-low.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  high only in IDLE; a command is accepted on an edge where `CMD_VALID & CMD_READY`.
- `CMD_MODO`  in  2  00 count up, 01 count down, 10 count down by 3, 11 load only.
- `CMD_D`  in  4  value to load into the counter.
- `CMD_N`  in  NW  number of counting steps; ignored when `CMD_MODO`=11.
- `ABORT`  in  1  synchronous; ends the current command early.
- `ENB`  out  1  counter enable.
- `MODO`  out  2  counter mode.
- `D`  out  4  counter parallel-load data.
- `Q`  in  4  counter output.
- `RCO`  in  1  counter ripple-carry/wrap flag.
- `DONE`  out  1  one-cycle pulse; `Q_FINAL`/`WRAPS` valid in that cycle.
- `Q_FINAL`  out  4  `Q` captured at end of command.
- `WRAPS`  out  4  `RCO` pulses counted during the command, saturating at 15.

## Operation
- Counter contract, on a rising `CLK` edge with `ENB`=1:
  - `MODO` 00: Q+1. 01: Q-1. 10: Q-3. 11: Q<=D. All mod 16.
  - With `ENB`=0 the counter holds.
- FSM states: IDLE, LOAD, COUNT, DRAIN.
- IDLE:
  - Outputs: `ENB`=0, `MODO`=00, `D`=0, `CMD_READY`=1.
  - On accept: latch `CMD_MODO`, `CMD_D`, `CMD_N`; clear `WRAPS`; go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: `ENB`=1, `MODO`=11, `D`=latched D.
  - Next state is DRAIN if load-only, `N`=0 or `ABORT`=1. Otherwise COUNT, with the remaining-step counter set to N.
- COUNT:
  - Outputs: `ENB`=1, `MODO`=latched mode, `D`=0.
  - Each edge decrements the remaining-step counter.
  - Go to DRAIN when remaining reaches 1 on that edge, or when `ABORT`=1. On abort, the counter still takes that edge's step.
- DRAIN (1 cycle):
  - Outputs: `ENB`=0, `MODO`=00, `D`=0.
  - At the closing edge: `Q_FINAL`<=`Q`, `DONE`<=1, go to IDLE.
- `WRAPS`:
  - Increments by 1, saturating at 15, on every edge in COUNT or DRAIN where `RCO`=1.
  - Holds its value after DONE until the next accept.
- `ABORT` is ignored in IDLE and DRAIN.
- A new command may be accepted in the IDLE cycle in which `DONE`=1. Back-to-back throughput is N+3 cycles per command.
- Reset (any time, including mid-command):
  - State goes to IDLE immediately.
  - `ENB`=0, `MODO`=00, `D`=0, `DONE`=0, `Q_FINAL`=0, `WRAPS`=0, `CMD_READY`=1.
  - The latched command is discarded.

## Timing
- Command accepted at edge k:
  - LOAD during cycle k→k+1; counter loads at edge k+1.
  - Counting steps occur at edges k+2 … k+N+1.
  - DRAIN during cycle k+N+1→k+N+2.
  - `DONE` is high for the cycle after edge k+N+2.
- Load-only or `N`=0: `DONE` follows edge k+2.
- `ABORT` seen at edge j in COUNT: the step at j happens, DRAIN follows, `DONE` after edge j+1.
- `ENB`, `MODO` and `D` are decoded from registered state only, with no combinational path from `CMD_*`. `CMD_READY` is a function of state only.
- `Q_FINAL`, `WRAPS` and `DONE` are registered.

## Test plan
- Reset low mid-COUNT → next cycle `ENB`=0, `CMD_READY`=1, `DONE`=0, `WRAPS`=0. After release, a load-only command with D=0101 gives `Q_FINAL`=0101.
- `CMD_MODO`=00, D=0000, N=16 → 16 up steps, `Q_FINAL`=0000, `WRAPS`=1, `DONE` 18 edges after accept.
- `CMD_MODO`=10, D=0000, N=5 → Q sequence 13,10,7,4,1; `Q_FINAL`=0001; `WRAPS` matches the model's `RCO` count.
- `CMD_MODO`=11, D=1001 → `MODO`=11 for exactly 1 cycle, then `ENB`=0; `Q_FINAL`=1001, `DONE` 2 edges after accept.
- `CMD_MODO`=01, D=1000, N=10, `ABORT` on the 3rd COUNT edge → `Q_FINAL`=0101, `DONE` one edge after the abort edge.
- Two back-to-back commands with `CMD_VALID` held high → the second is accepted in the `DONE` cycle; `WRAPS` restarts from 0.
